// File: rtl/counter_checker.sv
// counter_checker: watches a 4-bit counter, locks after LOCK_N consecutive +1 steps,
// then flags sequence breaks (err) and verified 15->0 rollovers (wrap).
module counter_checker #(
    parameter int LOCK_N = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q0,
    input  logic             q1,
    input  logic             q2,
    input  logic             q3,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [3:0]       last_q
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       exp_q, exp_d, mcnt_q, mcnt_d, last_q_q, last_q_d, sample, mcnt_inc;
    logic             err_q, err_d, wrap_q, wrap_d, match;
    logic [CNT_W-1:0] err_count_q, err_count_d, wrap_count_q, wrap_count_d;

    assign sample   = {q3, q2, q1, q0};
    assign match    = sample == exp_q;
    assign mcnt_inc = mcnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        mcnt_d       = mcnt_q;
        last_q_d     = last_q_q;
        err_d        = 1'b0;
        wrap_d       = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        if (en) begin
            last_q_d = sample;
            exp_d    = sample + 4'd1;
            if (state_q == IDLE) begin
                mcnt_d  = 4'd0;
                state_d = TRACK;
            end else if (state_q == TRACK) begin
                mcnt_d  = (match && mcnt_inc != 4'(LOCK_N)) ? mcnt_inc : 4'd0;
                state_d = (match && mcnt_inc == 4'(LOCK_N)) ? LOCK : TRACK;
            end else if (match) begin
                wrap_d       = sample == 4'd0;
                wrap_count_d = wrap_count_q + (sample == 4'd0 ? CNT_W'(1) : CNT_W'(0));
            end else begin
                err_d       = 1'b1;
                err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
                state_d     = TRACK;
                mcnt_d      = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= 4'd0;
            mcnt_q       <= 4'd0;
            last_q_q     <= 4'd0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            mcnt_q       <= mcnt_d;
            last_q_q     <= last_q_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = state_q == LOCK;
    assign err        = err_q;
    assign wrap       = wrap_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
    assign last_q     = last_q_q;
endmodule
